// File: rtl/goe_pkg.sv
// Shared constants for the packet output engine: beat tags, PHV verdict fields,
// metadata port position and the FSM state encoding.
package goe_pkg;

  localparam int DATA_W = 134;
  localparam int PHV_W  = 1024;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  localparam int PHV_DROP_BIT  = 1015;
  localparam int PHV_PORT_MSB  = 1023;
  localparam int PHV_PORT_LSB  = 1016;
  localparam int META_PORT_MSB = 127;
  localparam int META_PORT_LSB = 120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } goe_state_e;

endpackage

// File: rtl/goe_if.sv
// Bundle of the packet, PHV, transmit, config and statistics signals of goe.
// master is the surrounding pipeline, slave is the engine itself.
interface goe_if;
  import goe_pkg::*;

  logic              in_goe_data_wr;
  logic [DATA_W-1:0] in_goe_data;
  logic              in_goe_valid_wr;
  logic              in_goe_valid;
  logic              out_goe_alf;
  logic [PHV_W-1:0]  in_goe_phv;
  logic              in_goe_phv_wr;
  logic              out_goe_phv_alf;
  logic [DATA_W-1:0] out_goe_data;
  logic              out_goe_data_wr;
  logic              out_goe_valid_wr;
  logic              out_goe_valid;
  logic              in_goe_alf;
  logic [DATA_W-1:0] cin_goe_data;
  logic              cin_goe_data_wr;
  logic              cout_goe_ready;
  logic [DATA_W-1:0] cout_goe_data;
  logic              cout_goe_data_wr;
  logic              cin_goe_ready;
  logic [31:0]       goe_pkt_cnt;
  logic [31:0]       goe_drop_cnt;

  modport master (
    output in_goe_data_wr, in_goe_data, in_goe_valid_wr, in_goe_valid,
    output in_goe_phv, in_goe_phv_wr, in_goe_alf,
    output cin_goe_data, cin_goe_data_wr, cin_goe_ready,
    input  out_goe_alf, out_goe_phv_alf, out_goe_data, out_goe_data_wr,
    input  out_goe_valid_wr, out_goe_valid, cout_goe_ready, cout_goe_data,
    input  cout_goe_data_wr, goe_pkt_cnt, goe_drop_cnt
  );

  modport slave (
    input  in_goe_data_wr, in_goe_data, in_goe_valid_wr, in_goe_valid,
    input  in_goe_phv, in_goe_phv_wr, in_goe_alf,
    input  cin_goe_data, cin_goe_data_wr, cin_goe_ready,
    output out_goe_alf, out_goe_phv_alf, out_goe_data, out_goe_data_wr,
    output out_goe_valid_wr, out_goe_valid, cout_goe_ready, cout_goe_data,
    output cout_goe_data_wr, goe_pkt_cnt, goe_drop_cnt
  );

endinterface

// File: rtl/goe_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; writes into a full FIFO are
// dropped and latch a sticky overflow flag.
module goe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_wrEn;
  logic             w_rdEn;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_dout  = r_mem[r_rdPtr];
  assign w_wrEn  = i_wr && !o_full;
  assign w_rdEn  = i_rd && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[r_wrPtr] <= i_din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_rdEn) r_rdPtr <= r_rdPtr + AW'(1);
      r_count <= r_count + CW'(w_wrEn) - CW'(w_rdEn);
      if (i_wr && o_full) r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/goe.sv
// Packet output engine: buffers beats, validity and PHV per packet, then forwards
// (with the head's port byte rewritten) or drops each packet; config beats pass through.
module goe
  import goe_pkg::*;
#(
  parameter int DATA_DEPTH = 256,
  parameter int PKT_DEPTH  = 16,
  parameter int ALF_MARGIN = 128
) (
  input logic   clk,
  input logic   rst_n,
  goe_if.slave  bus
);

  localparam int DCW = $clog2(DATA_DEPTH) + 1;
  localparam int PCW = $clog2(PKT_DEPTH) + 1;
  localparam logic [DCW-1:0] DATA_ALF_TH = DCW'(DATA_DEPTH - ALF_MARGIN);
  localparam logic [PCW-1:0] PKT_ALF_TH  = PCW'(PKT_DEPTH - 2);

  logic [DATA_W-1:0] w_dataDout;
  logic              w_dataEmpty, w_dataFull, w_dataOvf;
  logic [DCW-1:0]    w_dataCount;
  logic              w_validDout, w_validEmpty, w_validFull, w_validOvf;
  logic [PCW-1:0]    w_validCount;
  logic [PHV_W-1:0]  w_phvDout;
  logic              w_phvEmpty, w_phvFull, w_phvOvf;
  logic [PCW-1:0]    w_phvCount;

  logic              w_dataPop;
  logic              w_pktPop;
  logic              w_sendBeat;
  logic              w_dropBeat;
  logic              w_isTail;
  logic [DATA_W-1:0] w_txBeat;
  goe_state_e        r_state, w_nextState;

  logic [7:0]        r_outPort;
  logic [DATA_W-1:0] r_txData;
  logic              r_txWr;
  logic              r_txValidWr;
  logic [31:0]       r_pktCnt;
  logic [31:0]       r_dropCnt;
  logic              r_alf;
  logic              r_phvAlf;
  logic [DATA_W-1:0] r_cfgData;
  logic              r_cfgWr;

  logic              w_unusedOvf;
  logic              w_unusedBits;

  goe_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_dataFifo (
    .clk(clk), .rst_n(rst_n),
    .i_wr(bus.in_goe_data_wr), .i_din(bus.in_goe_data), .i_rd(w_dataPop),
    .o_dout(w_dataDout), .o_empty(w_dataEmpty), .o_full(w_dataFull),
    .o_count(w_dataCount), .o_ovf(w_dataOvf)
  );

  goe_fifo #(.WIDTH(1), .DEPTH(PKT_DEPTH)) u_validFifo (
    .clk(clk), .rst_n(rst_n),
    .i_wr(bus.in_goe_valid_wr), .i_din(bus.in_goe_valid), .i_rd(w_pktPop),
    .o_dout(w_validDout), .o_empty(w_validEmpty), .o_full(w_validFull),
    .o_count(w_validCount), .o_ovf(w_validOvf)
  );

  goe_fifo #(.WIDTH(PHV_W), .DEPTH(PKT_DEPTH)) u_phvFifo (
    .clk(clk), .rst_n(rst_n),
    .i_wr(bus.in_goe_phv_wr), .i_din(bus.in_goe_phv), .i_rd(w_pktPop),
    .o_dout(w_phvDout), .o_empty(w_phvEmpty), .o_full(w_phvFull),
    .o_count(w_phvCount), .o_ovf(w_phvOvf)
  );

  assign w_unusedOvf  = w_dataOvf | w_validOvf | w_phvOvf;
  assign w_unusedBits = ^{w_dataFull, w_validFull, w_phvFull, w_phvDout[PHV_DROP_BIT-1:0]};

  assign w_isTail   = (w_dataDout[DATA_W-1 -: 2] == TAIL);
  assign w_sendBeat = w_dataPop && (r_state == SEND);
  assign w_dropBeat = w_dataPop && (r_state == DROP);

  // Downstream back-pressure only gates the start of a packet
  always_comb begin
    w_nextState = r_state;
    w_pktPop    = 1'b0;
    w_dataPop   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_validEmpty && !w_phvEmpty && !bus.in_goe_alf) begin
          w_pktPop    = 1'b1;
          w_nextState = (w_validDout && !w_phvDout[PHV_DROP_BIT]) ? SEND : DROP;
        end
      end
      SEND, DROP: begin
        if (!w_dataEmpty) begin
          w_dataPop = 1'b1;
          if (w_isTail) w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_txBeat = w_dataDout;
    if (w_dataDout[DATA_W-1 -: 2] == HEAD) w_txBeat[META_PORT_MSB:META_PORT_LSB] = r_outPort;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_outPort   <= '0;
      r_txData    <= '0;
      r_txWr      <= 1'b0;
      r_txValidWr <= 1'b0;
      r_pktCnt    <= '0;
      r_dropCnt   <= '0;
      r_alf       <= 1'b0;
      r_phvAlf    <= 1'b0;
      r_cfgData   <= '0;
      r_cfgWr     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      if (w_pktPop) r_outPort <= w_phvDout[PHV_PORT_MSB:PHV_PORT_LSB];
      r_txData    <= w_sendBeat ? w_txBeat : '0;
      r_txWr      <= w_sendBeat;
      r_txValidWr <= w_sendBeat && w_isTail;
      if (w_sendBeat && w_isTail) r_pktCnt <= r_pktCnt + 32'd1;
      if (w_dropBeat && w_isTail) r_dropCnt <= r_dropCnt + 32'd1;
      r_alf       <= (w_dataCount >= DATA_ALF_TH);
      r_phvAlf    <= (w_phvCount >= PKT_ALF_TH) || (w_validCount >= PKT_ALF_TH);
      r_cfgData   <= bus.cin_goe_data;
      r_cfgWr     <= bus.cin_goe_data_wr;
    end
  end

  assign bus.out_goe_data     = r_txData;
  assign bus.out_goe_data_wr  = r_txWr;
  assign bus.out_goe_valid_wr = r_txValidWr;
  assign bus.out_goe_valid    = r_txValidWr;
  assign bus.out_goe_alf      = r_alf;
  assign bus.out_goe_phv_alf  = r_phvAlf;
  assign bus.goe_pkt_cnt      = r_pktCnt;
  assign bus.goe_drop_cnt     = r_dropCnt;
  assign bus.cout_goe_data    = r_cfgData;
  assign bus.cout_goe_data_wr = r_cfgWr;
  assign bus.cout_goe_ready   = bus.cin_goe_ready;

endmodule

// File: tb/tb_goe.sv
// Directed self-checking bench for goe: forward, drop, back-pressure, alf
// thresholds, mid-packet reset and config pass-through.
module tb_goe;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   seen;

  goe_if bus ();

  goe #(.DATA_DEPTH(256), .PKT_DEPTH(16), .ALF_MARGIN(128)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  localparam logic [133:0] H1     = {2'b01, 4'h0, 128'h00112233445566778899aabbccddeeff};
  localparam logic [133:0] H1_OUT = {2'b01, 4'h0, 128'h05112233445566778899aabbccddeeff};
  localparam logic [133:0] B1     = {2'b11, 4'h0, 128'h0123456789abcdef0123456789abcdef};
  localparam logic [133:0] T1     = {2'b10, 4'h5, 128'hfedcba9876543210fedcba9876543210};
  localparam logic [133:0] HA     = {2'b01, 4'h0, 128'h77000000000000000000000000000001};
  localparam logic [133:0] HA_OUT = {2'b01, 4'h0, 128'h0a000000000000000000000000000001};
  localparam logic [133:0] TA     = {2'b10, 4'h2, 128'h00000000000000000000000000000002};
  localparam logic [133:0] HB     = {2'b01, 4'h0, 128'hff00000000000000000000000000c003};
  localparam logic [133:0] HB_OUT = {2'b01, 4'h0, 128'h0b00000000000000000000000000c003};
  localparam logic [133:0] BB     = {2'b11, 4'h0, 128'h5555aaaa5555aaaa5555aaaa5555aaaa};
  localparam logic [133:0] TB     = {2'b10, 4'hf, 128'h0000000000000000000000000000c004};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1023:0] makePhv(input logic [7:0] port, input logic drop);
    logic [1023:0] p;
    p = '0;
    p[1023:1016] = port;
    p[1015] = drop;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dWr, input logic [133:0] d, input logic vWr,
                               input logic v, input logic pWr, input logic [1023:0] p);
    bus.in_goe_data_wr  = dWr;
    bus.in_goe_data     = d;
    bus.in_goe_valid_wr = vWr;
    bus.in_goe_valid    = v;
    bus.in_goe_phv_wr   = pWr;
    bus.in_goe_phv      = p;
    tick();
    bus.in_goe_data_wr  = 1'b0;
    bus.in_goe_valid_wr = 1'b0;
    bus.in_goe_valid    = 1'b0;
    bus.in_goe_phv_wr   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [133:0] observed, input logic [133:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic countBeats(input int cycles);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.out_goe_data_wr) seen++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    bus.in_goe_data_wr  = 1'b0;
    bus.in_goe_data     = '0;
    bus.in_goe_valid_wr = 1'b0;
    bus.in_goe_valid    = 1'b0;
    bus.in_goe_phv      = '0;
    bus.in_goe_phv_wr   = 1'b0;
    bus.in_goe_alf      = 1'b0;
    bus.cin_goe_data    = '0;
    bus.cin_goe_data_wr = 1'b0;
    bus.cin_goe_ready   = 1'b1;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_data_wr", bus.out_goe_data_wr, 0);
    checkOutput("rst_data", bus.out_goe_data, 0);
    checkOutput("rst_valid_wr", bus.out_goe_valid_wr, 0);
    checkOutput("rst_alf", bus.out_goe_alf, 0);
    checkOutput("rst_phv_alf", bus.out_goe_phv_alf, 0);
    checkOutput("rst_pkt_cnt", bus.goe_pkt_cnt, 0);
    checkOutput("rst_cout_ready", bus.cout_goe_ready, 1);
    rst_n = 1'b1;

    $display("[TB] good packet");
    applyStimulus(1'b1, H1, 1'b0, 1'b0, 1'b1, makePhv(8'h05, 1'b0));
    applyStimulus(1'b1, B1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, T1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("t1_wr_edge0", bus.out_goe_data_wr, 0);
    tick();
    checkOutput("t1_wr_edge1", bus.out_goe_data_wr, 0);
    tick();
    checkOutput("t1_head_wr", bus.out_goe_data_wr, 1);
    checkOutput("t1_head", bus.out_goe_data, H1_OUT);
    checkOutput("t1_head_vwr", bus.out_goe_valid_wr, 0);
    tick();
    checkOutput("t1_body", bus.out_goe_data, B1);
    checkOutput("t1_body_wr", bus.out_goe_data_wr, 1);
    tick();
    checkOutput("t1_tail", bus.out_goe_data, T1);
    checkOutput("t1_tail_vwr", bus.out_goe_valid_wr, 1);
    checkOutput("t1_tail_valid", bus.out_goe_valid, 1);
    tick();
    checkOutput("t1_after_wr", bus.out_goe_data_wr, 0);
    checkOutput("t1_pkt_cnt", bus.goe_pkt_cnt, 1);

    $display("[TB] drop cases");
    applyStimulus(1'b1, H1, 1'b0, 1'b0, 1'b1, makePhv(8'h05, 1'b0));
    applyStimulus(1'b1, T1, 1'b1, 1'b0, 1'b0, '0);
    countBeats(6);
    checkOutput("t2a_beats", seen, 0);
    checkOutput("t2a_drop_cnt", bus.goe_drop_cnt, 1);
    applyStimulus(1'b1, H1, 1'b0, 1'b0, 1'b1, makePhv(8'h05, 1'b1));
    applyStimulus(1'b1, B1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, T1, 1'b1, 1'b1, 1'b0, '0);
    countBeats(8);
    checkOutput("t2b_beats", seen, 0);
    checkOutput("t2b_drop_cnt", bus.goe_drop_cnt, 2);
    checkOutput("t2b_pkt_cnt", bus.goe_pkt_cnt, 1);

    $display("[TB] back-pressure");
    bus.in_goe_alf = 1'b1;
    applyStimulus(1'b1, HA, 1'b0, 1'b0, 1'b1, makePhv(8'h0a, 1'b0));
    applyStimulus(1'b1, TA, 1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, HB, 1'b0, 1'b0, 1'b1, makePhv(8'h0b, 1'b0));
    applyStimulus(1'b1, BB, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, TB, 1'b1, 1'b1, 1'b0, '0);
    countBeats(20);
    checkOutput("t3_blocked_beats", seen, 0);
    bus.in_goe_alf = 1'b0;
    tick();
    checkOutput("t3_start_wr", bus.out_goe_data_wr, 0);
    tick();
    checkOutput("t3_a_head", bus.out_goe_data, HA_OUT);
    checkOutput("t3_a_head_wr", bus.out_goe_data_wr, 1);
    tick();
    checkOutput("t3_a_tail", bus.out_goe_data, TA);
    checkOutput("t3_a_tail_vwr", bus.out_goe_valid_wr, 1);
    tick();
    checkOutput("t3_gap_wr", bus.out_goe_data_wr, 0);
    tick();
    checkOutput("t3_b_head", bus.out_goe_data, HB_OUT);
    bus.in_goe_alf = 1'b1;
    tick();
    checkOutput("t3_b_body", bus.out_goe_data, BB);
    checkOutput("t3_b_body_wr", bus.out_goe_data_wr, 1);
    tick();
    checkOutput("t3_b_tail", bus.out_goe_data, TB);
    checkOutput("t3_b_tail_vwr", bus.out_goe_valid_wr, 1);
    tick();
    checkOutput("t3_pkt_cnt", bus.goe_pkt_cnt, 3);

    $display("[TB] alf thresholds");
    for (int i = 0; i < 128; i++) applyStimulus(1'b1, B1, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("t4_alf_lag", bus.out_goe_alf, 0);
    tick();
    checkOutput("t4_alf_rise", bus.out_goe_alf, 1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, makePhv(8'h01, 1'b0));
    checkOutput("t4_phv_alf_lag", bus.out_goe_phv_alf, 0);
    tick();
    checkOutput("t4_phv_alf_rise", bus.out_goe_phv_alf, 1);

    $display("[TB] reset mid-packet");
    bus.in_goe_alf = 1'b0;
    applyStimulus(1'b1, H1, 1'b0, 1'b0, 1'b1, makePhv(8'h05, 1'b0));
    rst_n = 1'b0;
    applyStimulus(1'b1, B1, 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    checkOutput("t5_alf", bus.out_goe_alf, 0);
    checkOutput("t5_phv_alf", bus.out_goe_phv_alf, 0);
    checkOutput("t5_pkt_cnt", bus.goe_pkt_cnt, 0);
    checkOutput("t5_drop_cnt", bus.goe_drop_cnt, 0);
    checkOutput("t5_data_wr", bus.out_goe_data_wr, 0);
    countBeats(4);
    checkOutput("t5_idle_beats", seen, 0);
    applyStimulus(1'b1, H1, 1'b0, 1'b0, 1'b1, makePhv(8'h05, 1'b0));
    applyStimulus(1'b1, B1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, T1, 1'b1, 1'b1, 1'b0, '0);
    tick();
    tick();
    checkOutput("t5_head", bus.out_goe_data, H1_OUT);
    tick();
    checkOutput("t5_body", bus.out_goe_data, B1);
    tick();
    checkOutput("t5_tail", bus.out_goe_data, T1);
    checkOutput("t5_tail_vwr", bus.out_goe_valid_wr, 1);
    countBeats(5);
    checkOutput("t5_stale_beats", seen, 0);
    checkOutput("t5_pkt_cnt_after", bus.goe_pkt_cnt, 1);

    $display("[TB] config pass-through");
    for (int i = 0; i < 4; i++) begin
      bus.cin_goe_data    = {2'b01, 4'(i), 128'hc0ffee00c0ffee00c0ffee0000000000 + 128'(i * 7)};
      bus.cin_goe_data_wr = 1'b1;
      tick();
      checkOutput($sformatf("t6_cfg_data%0d", i), bus.cout_goe_data,
                  {2'b01, 4'(i), 128'hc0ffee00c0ffee00c0ffee0000000000 + 128'(i * 7)});
      checkOutput($sformatf("t6_cfg_wr%0d", i), bus.cout_goe_data_wr, 1);
      checkOutput($sformatf("t6_cfg_ready%0d", i), bus.cout_goe_ready, 1);
    end
    bus.cin_goe_data_wr = 1'b0;
    tick();
    checkOutput("t6_cfg_wr_off", bus.cout_goe_data_wr, 0);
    bus.cin_goe_ready = 1'b0;
    #1;
    checkOutput("t6_ready_follow", bus.cout_goe_ready, 0);

    checkOutput("no_ovf", dut.w_unusedOvf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
